// File: rtl/osc_meter_pkg.sv
// Shared types and sizing for the oscillator frequency meter.
// FSM state encoding, synchronizer depth and gate counter width.
package osc_meter_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    GATE = 2'd1,
    DONE = 2'd2
  } state_t;

  localparam int SYNC_STAGES = 2;
  localparam int GATE_CNT_W  = 16;

endpackage

// File: rtl/gray2bin.sv
// Gray-to-binary converter, purely combinational, zero latency.
// No flow control: output follows input within the same cycle.
module gray2bin #(
  parameter int W = 32
) (
  input  logic [W-1:0] gray,
  output logic [W-1:0] bin
);

  // Each binary bit is the XOR of all Gray bits at or above it.
  always_comb begin
    bin = '0;
    for (int i = 0; i < W; i++) begin
      bin[i] = ^(gray >> i);
    end
  end

endmodule

// File: rtl/osc_freq_meter.sv
// Oscillator frequency meter: counts Gray-coded oscillator ticks over a GATE_CYCLES window.
// VALID rises GATE_CYCLES edges after an accepted START; result holds until VALID&READY.
module osc_freq_meter
  import osc_meter_pkg::*;
#(
  parameter int COUNTER_LENGTH = 32,
  parameter int GATE_CYCLES    = 1024
) (
  input  logic                      CLK,
  input  logic                      RESET_N,
  input  logic [COUNTER_LENGTH-1:0] COUNT_GRAY,
  input  logic                      START,
  input  logic                      READY,
  output logic [COUNTER_LENGTH-1:0] DELTA,
  output logic                      VALID,
  output logic                      BUSY,
  output logic                      OVERRUN
);

  localparam logic [GATE_CNT_W-1:0] GATE_INIT = GATE_CNT_W'(GATE_CYCLES - 1);

  logic [COUNTER_LENGTH-1:0] sync_q [SYNC_STAGES];
  logic [COUNTER_LENGTH-1:0] sync_d [SYNC_STAGES];
  logic [COUNTER_LENGTH-1:0] sync_bin;

  state_t                    state_q, state_d;
  logic [COUNTER_LENGTH-1:0] start_snap_q, start_snap_d;
  logic [GATE_CNT_W-1:0]     gate_cnt_q, gate_cnt_d;
  logic [COUNTER_LENGTH-1:0] delta_q, delta_d;
  logic                      valid_q, valid_d;
  logic                      overrun_q, overrun_d;

  // Gray coding keeps the synchronized sample within one step of the true count.
  gray2bin #(.W(COUNTER_LENGTH)) u_gray2bin (
    .gray (sync_q[SYNC_STAGES-1]),
    .bin  (sync_bin)
  );

  always_comb begin
    sync_d[0] = COUNT_GRAY;
    for (int i = 1; i < SYNC_STAGES; i++) begin
      sync_d[i] = sync_q[i-1];
    end

    state_d      = state_q;
    start_snap_d = start_snap_q;
    gate_cnt_d   = gate_cnt_q;
    delta_d      = delta_q;
    valid_d      = valid_q;
    overrun_d    = overrun_q;

    unique case (state_q)
      IDLE: begin
        if (START) begin
          start_snap_d = sync_bin;
          gate_cnt_d   = GATE_INIT;
          overrun_d    = 1'b0;
          state_d      = GATE;
        end
      end
      GATE: begin
        if (START) overrun_d = 1'b1;
        if (gate_cnt_q != '0) begin
          gate_cnt_d = gate_cnt_q - GATE_CNT_W'(1);
        end else begin
          // Modulo subtraction absorbs counter wrap-around.
          delta_d = sync_bin - start_snap_q;
          valid_d = 1'b1;
          state_d = DONE;
        end
      end
      DONE: begin
        if (START) overrun_d = 1'b1;
        if (valid_q && READY) begin
          valid_d = 1'b0;
          state_d = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge CLK or negedge RESET_N) begin
    if (!RESET_N) begin
      for (int i = 0; i < SYNC_STAGES; i++) begin
        sync_q[i] <= '0;
      end
      state_q      <= IDLE;
      start_snap_q <= '0;
      gate_cnt_q   <= '0;
      delta_q      <= '0;
      valid_q      <= 1'b0;
      overrun_q    <= 1'b0;
    end else begin
      sync_q       <= sync_d;
      state_q      <= state_d;
      start_snap_q <= start_snap_d;
      gate_cnt_q   <= gate_cnt_d;
      delta_q      <= delta_d;
      valid_q      <= valid_d;
      overrun_q    <= overrun_d;
    end
  end

  assign DELTA   = delta_q;
  assign VALID   = valid_q;
  assign OVERRUN = overrun_q;
  assign BUSY    = (state_q != IDLE);

endmodule

// File: tb/tb_osc_freq_meter.sv
// Directed bench for osc_freq_meter: two instances (16- and 100-cycle gates) share one oscillator source.
// Expected deltas are queued at START and compared when each result is handshaken out.
module tb_osc_freq_meter;

  logic        clk = 1'b0;
  logic        rst_n;
  logic [31:0] count_bin;
  logic [31:0] load_val;
  logic        load, inc;
  logic [31:0] count_gray;

  logic        start_a, ready_a, valid_a, busy_a, overrun_a;
  logic        start_b, ready_b, valid_b, busy_b, overrun_b;
  logic [31:0] delta_a, delta_b;

  int          checks   = 0;
  int          failures = 0;
  logic [31:0] exp_q [$];

  always #5 clk = ~clk;

  // Free-running oscillator model: one binary step per CLK when inc is set.
  always @(posedge clk) begin
    if (load)     count_bin <= load_val;
    else if (inc) count_bin <= count_bin + 32'd1;
  end
  assign count_gray = count_bin ^ (count_bin >> 1);

  osc_freq_meter #(.COUNTER_LENGTH(32), .GATE_CYCLES(16)) dut_a (
    .CLK(clk), .RESET_N(rst_n), .COUNT_GRAY(count_gray), .START(start_a), .READY(ready_a),
    .DELTA(delta_a), .VALID(valid_a), .BUSY(busy_a), .OVERRUN(overrun_a)
  );

  osc_freq_meter #(.COUNTER_LENGTH(32), .GATE_CYCLES(100)) dut_b (
    .CLK(clk), .RESET_N(rst_n), .COUNT_GRAY(count_gray), .START(start_b), .READY(ready_b),
    .DELTA(delta_b), .VALID(valid_b), .BUSY(busy_b), .OVERRUN(overrun_b)
  );

  task automatic cyc();
    @(negedge clk);
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
    end
  endtask

  // Called at a negedge; returns at the negedge following the START edge (t0).
  task automatic pulse_start(input bit sel);
    if (sel) start_b = 1'b1; else start_a = 1'b1;
    cyc();
    start_a = 1'b0;
    start_b = 1'b0;
  endtask

  task automatic wait_valid(input bit sel, input int budget, output int n);
    n = 0;
    while (((sel ? valid_b : valid_a) !== 1'b1) && n < budget) begin
      cyc();
      n++;
    end
  endtask

  task automatic accept(input bit sel, input string tag);
    logic [31:0] exp;
    if (exp_q.size() == 0) begin
      checks++;
      failures++;
      $error("FAIL %s_scoreboard observed=empty expected=entry", tag);
    end else begin
      exp = exp_q.pop_front();
      chk({tag, "_delta"}, sel ? delta_b : delta_a, exp);
    end
    if (sel) ready_b = 1'b1; else ready_a = 1'b1;
    cyc();
    ready_a = 1'b0;
    ready_b = 1'b0;
    chk({tag, "_valid_after_hs"}, 32'(sel ? valid_b : valid_a), 32'd0);
    chk({tag, "_busy_after_hs"},  32'(sel ? busy_b  : busy_a),  32'd0);
  endtask

  initial begin
    int n;
    int stable;
    int seen;

    start_a = 1'b0; start_b = 1'b0; ready_a = 1'b0; ready_b = 1'b0;
    load = 1'b1; inc = 1'b0; load_val = 32'h0000_1234;
    rst_n = 1'b0;
    repeat (3) cyc();

    chk("rst_valid_a",   32'(valid_a),   32'd0);
    chk("rst_busy_a",    32'(busy_a),    32'd0);
    chk("rst_overrun_a", 32'(overrun_a), 32'd0);
    chk("rst_delta_a",   delta_a,        32'd0);
    chk("rst_valid_b",   32'(valid_b),   32'd0);
    chk("rst_busy_b",    32'(busy_b),    32'd0);

    rst_n = 1'b1;
    repeat (3) cyc();

    // Constant count: zero delta, VALID exactly 16 edges after t0.
    exp_q.push_back(32'd0);
    pulse_start(1'b0);
    chk("const_busy_t0", 32'(busy_a), 32'd1);
    chk("const_valid_early", 32'(valid_a), 32'd0);
    wait_valid(1'b0, 40, n);
    chk("const_latency", 32'(n), 32'd16);

    // Consumer stalls 50 cycles; result must hold.
    stable = 0;
    repeat (50) begin
      cyc();
      if (valid_a === 1'b1 && busy_a === 1'b1 && exp_q.size() != 0 && delta_a === exp_q[0]) stable++;
    end
    chk("stall_hold", 32'(stable), 32'd50);
    accept(1'b0, "const");

    // Incrementing count, 100-cycle gate.
    load_val = 32'h0000_1000;
    repeat (2) cyc();
    load = 1'b0; inc = 1'b1;
    repeat (4) cyc();
    exp_q.push_back(32'd100);
    pulse_start(1'b1);
    wait_valid(1'b1, 200, n);
    chk("inc_latency", 32'(n), 32'd100);
    accept(1'b1, "inc");

    // Window spans the 2^32 wrap.
    load = 1'b1; inc = 1'b0; load_val = 32'hFFFF_FFC0;
    repeat (2) cyc();
    load = 1'b0; inc = 1'b1;
    repeat (3) cyc();
    exp_q.push_back(32'd100);
    pulse_start(1'b1);
    wait_valid(1'b1, 200, n);
    chk("wrap_latency", 32'(n), 32'd100);
    accept(1'b1, "wrap");

    // Second START during GATE is ignored but flags OVERRUN.
    exp_q.push_back(32'd16);
    pulse_start(1'b0);
    repeat (4) cyc();
    start_a = 1'b1;
    cyc();
    start_a = 1'b0;
    chk("ovr_set", 32'(overrun_a), 32'd1);
    chk("ovr_busy", 32'(busy_a), 32'd1);
    wait_valid(1'b0, 40, n);
    chk("ovr_latency", 32'(n), 32'd11);
    chk("ovr_sticky_done", 32'(overrun_a), 32'd1);

    // START coinciding with the handshake edge is also ignored.
    if (exp_q.size() != 0) chk("ovr_delta", delta_a, exp_q.pop_front());
    ready_a = 1'b1; start_a = 1'b1;
    cyc();
    ready_a = 1'b0; start_a = 1'b0;
    chk("hs_start_valid", 32'(valid_a), 32'd0);
    chk("hs_start_busy", 32'(busy_a), 32'd0);
    chk("hs_start_overrun", 32'(overrun_a), 32'd1);

    // Next accepted START clears OVERRUN.
    exp_q.push_back(32'd16);
    pulse_start(1'b0);
    chk("ovr_clear", 32'(overrun_a), 32'd0);
    wait_valid(1'b0, 40, n);
    chk("rerun_latency", 32'(n), 32'd16);
    accept(1'b0, "rerun");

    // Asynchronous reset in the middle of a gate window.
    pulse_start(1'b0);
    repeat (7) cyc();
    @(posedge clk);
    #1 rst_n = 1'b0;
    #1;
    chk("mid_rst_busy", 32'(busy_a), 32'd0);
    chk("mid_rst_valid", 32'(valid_a), 32'd0);
    chk("mid_rst_delta", delta_a, 32'd0);
    cyc();
    rst_n = 1'b1;
    seen = 0;
    repeat (30) begin
      cyc();
      if (valid_a !== 1'b0 || busy_a !== 1'b0) seen++;
    end
    chk("mid_rst_no_valid", 32'(seen), 32'd0);

    exp_q.push_back(32'd16);
    pulse_start(1'b0);
    chk("post_rst_busy", 32'(busy_a), 32'd1);
    wait_valid(1'b0, 40, n);
    chk("post_rst_latency", 32'(n), 32'd16);
    accept(1'b0, "post_rst");

    chk("sb_drained", 32'(exp_q.size()), 32'd0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
